uart_byte_tx: RTL and testbench

//  - 8N1 UART transmitter: accepts bytes on a valid/ready stream, serialises them LSB-first onto txd.
//  - Drives the serial line into chip_top's uart_RX (bench-side host model and on-chip loopback/debug TX).
//  - One-entry holding register behind the shift register, so back-to-back frames leave no idle gap.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_gen.sv | 38 +++
 rtl/uart_byte_tx.sv | 134 +++++++++++++
 tb/tb_uart_byte_tx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame geometry and baud defaults.
package uart_pkg;

  localparam int DATA_BITS   = 8;
  // 100 MHz system clock divided down to 115200 baud.
  localparam int DEFAULT_DIV = 868;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Width of a counter that spans 0..div-1 (never less than one bit).
  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIV-1, wraps, and flags the last cycle of each bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: restart on clear or after the last cycle of a bit period.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter with a one-entry holding register so frames can run back to back.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int DIV       = DEFAULT_DIV,
  parameter int STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       txd,
  output logic       busy
);

  localparam int               IDX_W     = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  logic [1:0]           state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 txd_q, txd_d;
  logic                 baud_clear;
  logic                 baud_tick;

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud (
    .clock  (clock),
    .resetn (resetn),
    .clear  (baud_clear),
    .tick   (baud_tick)
  );

  // Frame sequencing, hold-register handshake and the next value of the serial line.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    baud_clear  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          state_d     = ST_START;
          baud_clear  = 1'b1;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d    = ST_STOP;
            stop_idx_d = 1'b0;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: begin // ST_STOP
        if (baud_tick) begin
          if (stop_idx_q == LAST_STOP) begin
            if (hold_full_q) begin
              // Chain straight into the next start bit: no idle cycle between frames.
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              state_d     = ST_START;
              baud_clear  = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
    endcase

    // Accept only into an empty hold; a held byte is never overwritten.
    if (in_valid && !hold_full_q) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end

    // txd is registered, so it is derived from where the FSM is going.
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and drops the held byte.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      txd_q       <= txd_d;
    end
  end

  assign in_ready = !hold_full_q;
  assign txd      = txd_q;
  assign busy     = (state_q != ST_IDLE) || hold_full_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: frame-level reference model plus directed corner cases.
module tb_uart_byte_tx;

  localparam int DIV_A   = 4;
  localparam int FRAME_A = 10 * DIV_A;
  localparam int DIV_B   = 868;

  logic       clk;
  logic       resetn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       txd;
  logic       busy;
  logic [7:0] b_in_data;
  logic       b_in_valid;
  logic       b_in_ready;
  logic       b_txd;
  logic       b_busy;

  uart_byte_tx #(.DIV(DIV_A), .STOP_BITS(1)) dut_a (
    .clock    (clk),
    .resetn   (resetn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .txd      (txd),
    .busy     (busy)
  );

  uart_byte_tx #(.DIV(DIV_B), .STOP_BITS(2)) dut_b (
    .clock    (clk),
    .resetn   (resetn),
    .in_data  (b_in_data),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .txd      (b_txd),
    .busy     (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  // Reference model: each accepted byte becomes a frame with a start edge.
  typedef struct {
    logic [7:0] data;
    int         start;
  } frame_t;

  frame_t fq[$];
  int     e        = 0;
  int     last_end = 0;
  int     acc_edge = 0;
  int     acc_cnt  = 0;
  bit     txd_log[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, e, act, exp);
    end
  endtask

  function automatic bit m_ready(input int at);
    foreach (fq[i]) if (fq[i].start > at) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_busy(input int at);
    foreach (fq[i]) if (fq[i].start + FRAME_A > at) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_txd(input int at);
    int k;
    foreach (fq[i]) begin
      if (at >= fq[i].start && at < fq[i].start + FRAME_A) begin
        k = (at - fq[i].start) / DIV_A;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return fq[i].data[k-1];
      end
    end
    return 1'b1;
  endfunction

  // One clock: update the model at the edge, then compare outputs on the falling edge.
  task automatic tick();
    bit rdy_pre;
    int st;
    rdy_pre = m_ready(e);
    @(posedge clk);
    if (!resetn) begin
      fq.delete();
      last_end = 0;
    end else if (in_valid && rdy_pre) begin
      st = (e + 2 > last_end) ? e + 2 : last_end;
      fq.push_back('{in_data, st});
      last_end = st + FRAME_A;
      acc_edge = e + 1;
      acc_cnt++;
    end
    e++;
    while (fq.size() > 0 && fq[0].start + FRAME_A <= e) void'(fq.pop_front());
    @(negedge clk);
    txd_log.push_back(txd);
    chk("txd", {31'd0, txd}, {31'd0, m_txd(e)});
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready(e)});
    chk("busy", {31'd0, busy}, {31'd0, m_busy(e)});
    $display("edge %0d: valid=%0b data=%02h ready=%0b txd=%0b busy=%0b", e, in_valid, in_data,
             in_ready, txd, busy);
  endtask

  task automatic send_a(input logic [7:0] d);
    int n0;
    n0 = acc_cnt;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && acc_cnt == n0; i++) tick();
    in_valid = 1'b0;
    chk("accept", acc_cnt - n0, 1);
  endtask

  task automatic wait_edge(input int target);
    while (e < target) tick();
  endtask

  // Mid-bit sampling of the logged line, like a receiver would.
  task automatic decode(input int st, output logic [7:0] b);
    chk("start_bit", {31'd0, txd_log[st + DIV_A/2]}, 0);
    for (int k = 1; k <= 8; k++) b[k-1] = txd_log[st + DIV_A*k + DIV_A/2];
    chk("stop_bit", {31'd0, txd_log[st + 9*DIV_A + DIV_A/2]}, 1);
  endtask

  initial begin
    int          st;
    int          z;
    logic [7:0]  rx;
    int          t_acc;
    int          t_low;
    int          rel;
    int          low_cnt;
    int          stop_busy;
    int          stop_low;
    logic        start_end;
    bit          found;

    vecs[0] = '{8'h55, 10'b1010101010};
    vecs[1] = '{8'hA3, 10'b1101000110};
    vecs[2] = '{8'h0F, 10'b1000011110};
    vecs[3] = '{8'h00, 10'b1000000000};
    vecs[4] = '{8'hFF, 10'b1111111110};
    vecs[5] = '{8'h81, 10'b1100000010};

    txd_log.push_back(1'b1);
    resetn = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    b_in_valid = 1'b0; b_in_data = 8'h00;
    repeat (3) tick();
    chk("reset_txd", {31'd0, txd}, 1);
    chk("reset_ready", {31'd0, in_ready}, 1);
    chk("reset_busy", {31'd0, busy}, 0);

    // Idle line after reset release.
    resetn = 1'b1;
    z = 0;
    repeat (100) begin
      tick();
      if (txd !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) z++;
    end
    chk("idle_100", z, 0);

    // Table of single frames: every cycle compared against the expected frame bit.
    foreach (vecs[v]) begin
      send_a(vecs[v].data);
      st = acc_edge + 1;
      chk("idle_on_accept_edge", {31'd0, txd_log[acc_edge]}, 1);
      wait_edge(st + FRAME_A + 2);
      for (int i = 0; i < FRAME_A; i++)
        chk("frame_vec", {31'd0, txd_log[st + i]}, {31'd0, vecs[v].frame[i / DIV_A]});
      chk("after_frame_idle", {31'd0, txd_log[st + FRAME_A]}, 1);
      repeat (3) tick();
    end

    // Back-to-back with in_valid held high.
    in_data = 8'hA3; in_valid = 1'b1;
    z = acc_cnt;
    for (int i = 0; i < 50 && acc_cnt == z; i++) tick();
    st = acc_edge + 1;
    in_data = 8'h0F;
    for (int i = 0; i < 100 && acc_cnt == z + 1; i++) tick();
    in_valid = 1'b0;
    chk("b2b_accepts", acc_cnt - z, 2);
    wait_edge(st + 2*FRAME_A + 2);
    decode(st, rx);
    chk("b2b_byte0", rx, 8'hA3);
    decode(st + FRAME_A, rx);
    chk("b2b_byte1", rx, 8'h0F);
    chk("b2b_no_gap_stop", {31'd0, txd_log[st + FRAME_A - 1]}, 1);
    chk("b2b_no_gap_start", {31'd0, txd_log[st + FRAME_A]}, 0);
    repeat (5) tick();

    // Held byte must survive a competing 0xFF while the hold is full.
    send_a(8'h81);
    st = acc_edge + 1;
    send_a(8'h3C);
    in_data = 8'hFF; in_valid = 1'b1;
    repeat (5) tick();
    chk("hold_full_ready", {31'd0, in_ready}, 0);
    z = acc_cnt;
    for (int i = 0; i < 200 && acc_cnt == z; i++) tick();
    in_valid = 1'b0;
    wait_edge(st + 3*FRAME_A + 2);
    decode(st, rx);
    chk("hold_byte0", rx, 8'h81);
    decode(st + FRAME_A, rx);
    chk("hold_byte1", rx, 8'h3C);
    decode(st + 2*FRAME_A, rx);
    chk("hold_byte2", rx, 8'hFF);
    repeat (5) tick();

    // Reset during data bit 3 of 0x00.
    send_a(8'h00);
    st = acc_edge + 1;
    wait_edge(st + 4*DIV_A + 1);
    chk("bit3_low", {31'd0, txd_log[st + 4*DIV_A + 1]}, 0);
    resetn = 1'b0;
    tick();
    chk("abort_txd", {31'd0, txd}, 1);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_ready", {31'd0, in_ready}, 1);
    resetn = 1'b1;
    z = 0;
    repeat (30) begin
      tick();
      if (txd !== 1'b1) z++;
    end
    chk("no_zero_after_abort", z, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (100) tick();

    // Two stop bits at the real baud divider.
    chk("b_ready_idle", {31'd0, b_in_ready}, 1);
    b_in_data = 8'h41; b_in_valid = 1'b1;
    tick();
    t_acc = e;
    b_in_valid = 1'b0;
    found = 1'b0;
    t_low = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      tick();
      if (b_txd === 1'b0) begin
        found = 1'b1;
        t_low = e;
      end
    end
    chk("b_start_found", {31'd0, found}, 1);
    chk("b_latency", t_low - t_acc, 1);
    if (found) begin
      low_cnt = 1; stop_busy = 0; stop_low = 0; start_end = 1'b0; rx = 8'h00;
      for (int i = 0; i < 11*DIV_B + 10; i++) begin
        tick();
        rel = e - t_low;
        if (rel < DIV_B && b_txd === 1'b0) low_cnt++;
        if (rel == DIV_B) start_end = b_txd;
        if (rel >= DIV_B && rel < 9*DIV_B && (rel % DIV_B) == DIV_B/2) rx = {b_txd, rx[7:1]};
        if (rel >= 9*DIV_B && b_busy === 1'b1) stop_busy++;
        if (rel >= 9*DIV_B && rel < 11*DIV_B && b_txd !== 1'b1) stop_low++;
      end
      chk("b_start_width", low_cnt, DIV_B);
      chk("b_start_end", {31'd0, start_end}, 1);
      chk("b_rx_byte", rx, 8'h41);
      chk("b_stop_width", stop_busy, 2*DIV_B);
      chk("b_stop_level", stop_low, 0);
      chk("b_idle_busy", {31'd0, b_busy}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
